// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS main controller (FETCH/DECODE/EXE/MEM/WB).
// In: clk, reset, opCode, func, zero, im_ready, dm_ready. Out: datapath controls, state, instr_done, illegal, instr_cnt.
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opCode,
  input  logic [5:0]  func,
  input  logic        zero,
  input  logic        im_ready,
  input  logic        dm_ready,
  output logic        PCWr,
  output logic        IRWr,
  output logic [2:0]  NPCOp,
  output logic [1:0]  A3Sel,
  output logic [1:0]  RFWDSel,
  output logic        RFWr,
  output logic        ExtOp,
  output logic        BSel,
  output logic [2:0]  ALUOp,
  output logic        DMWr,
  output logic [2:0]  state,
  output logic        instr_done,
  output logic        illegal,
  output logic [31:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;

  logic is_add, is_sub, is_jr, is_ori, is_lui;
  logic is_lw, is_sw, is_beq, is_j, is_jal;
  logic is_alu, legal;

  assign is_add = (opCode == OP_R) && (func == FN_ADD);
  assign is_sub = (opCode == OP_R) && (func == FN_SUB);
  assign is_jr  = (opCode == OP_R) && (func == FN_JR);
  assign is_ori = (opCode == OP_ORI);
  assign is_lui = (opCode == OP_LUI);
  assign is_lw  = (opCode == OP_LW);
  assign is_sw  = (opCode == OP_SW);
  assign is_beq = (opCode == OP_BEQ);
  assign is_j   = (opCode == OP_J);
  assign is_jal = (opCode == OP_JAL);

  assign is_alu = is_add | is_sub | is_ori | is_lui;
  assign legal  = is_alu | is_lw | is_sw | is_beq |
                  is_j | is_jal | is_jr;

  // Per-instruction datapath selects, held through EXE/MEM/WB.
  logic [2:0] sel_alu;
  logic       sel_b;
  logic       sel_ext;

  always_comb begin
    sel_alu = 3'b000;
    sel_b   = 1'b0;
    sel_ext = 1'b0;
    unique case (1'b1)
      is_sub: sel_alu = 3'b001;
      is_ori: begin
        sel_alu = 3'b011;
        sel_b   = 1'b1;
      end
      is_lui: begin
        sel_alu = 3'b100;
        sel_b   = 1'b1;
      end
      is_lw, is_sw: begin
        sel_b   = 1'b1;
        sel_ext = 1'b1;
      end
      is_beq: begin
        sel_alu = 3'b001;
        sel_ext = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    PCWr       = 1'b0;
    IRWr       = 1'b0;
    NPCOp      = 3'b000;
    A3Sel      = 2'b00;
    RFWDSel    = 2'b00;
    RFWr       = 1'b0;
    ExtOp      = 1'b0;
    BSel       = 1'b0;
    ALUOp      = 3'b000;
    DMWr       = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (im_ready) begin
          IRWr    = 1'b1;
          PCWr    = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_j || is_jal) begin
          PCWr       = 1'b1;
          NPCOp      = 3'b010;
          instr_done = 1'b1;
          state_d    = S_FETCH;
          if (is_jal) begin
            RFWr    = 1'b1;
            A3Sel   = 2'b10;
            RFWDSel = 2'b10;
          end
        end else if (is_jr) begin
          PCWr       = 1'b1;
          NPCOp      = 3'b011;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (!legal) begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        ALUOp = sel_alu;
        BSel  = sel_b;
        ExtOp = sel_ext;
        if (is_beq) begin
          PCWr       = zero;
          NPCOp      = zero ? 3'b001 : 3'b000;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_alu) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        ALUOp = sel_alu;
        BSel  = sel_b;
        ExtOp = sel_ext;
        if (is_sw) begin
          DMWr = 1'b1;
          if (dm_ready) begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        end else if (is_lw) begin
          if (dm_ready) state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        ALUOp      = sel_alu;
        BSel       = sel_b;
        ExtOp      = sel_ext;
        RFWr       = is_alu | is_lw;
        A3Sel      = (is_add | is_sub) ? 2'b01 : 2'b00;
        RFWDSel    = is_lw ? 2'b01 : 2'b00;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset suppresses every write so an abandoned instruction leaves no trace.
    if (reset) begin
      PCWr       = 1'b0;
      IRWr       = 1'b0;
      NPCOp      = 3'b000;
      RFWr       = 1'b0;
      DMWr       = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end

    cnt_d = cnt_q + {31'd0, instr_done};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state     = state_q;
  assign instr_cnt = cnt_q;

endmodule
